// File: rtl/icache_pkg.sv
// Shared defaults and flush-state encoding for the instruction-cache lookup stage.
// Optional feature macro used by this slice: ICACHE_BYPASS_EN.
package icache_pkg;

   localparam int NUM_WAYS       = 4;
   localparam int SET_BITS_WIDTH = 4;
   localparam int TAG_WIDTH      = 8;
   localparam int STATUS_WIDTH   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_e;

endpackage

// File: rtl/icache_way_array.sv
// Per-set flop array with per-way masked write, optional synchronous clear and,
// when ICACHE_BYPASS_EN is defined, a write-to-read forwarding mux.
module icache_way_array #(
   parameter int NUM_WAYS  = 4,
   parameter int WAY_WIDTH = 8,
   parameter int SET_BITS  = 4,
   parameter bit HAS_CLEAR = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_en,
   input  logic [SET_BITS-1:0]           clr_addr,
   input  logic                          w_en,
   input  logic [SET_BITS-1:0]           w_addr,
   input  logic [NUM_WAYS*WAY_WIDTH-1:0] w_data,
   input  logic [NUM_WAYS-1:0]           w_mask,
   input  logic [SET_BITS-1:0]           r_addr,
   output logic [NUM_WAYS*WAY_WIDTH-1:0] r_data
);

   localparam int NUM_SETS = 2**SET_BITS;
   localparam int WORD_W   = NUM_WAYS*WAY_WIDTH;

   logic [WORD_W-1:0] mem [NUM_SETS];

   // Arrays built without HAS_CLEAR keep their contents through reset.
   always_ff @(posedge clk) begin
      if (HAS_CLEAR && !rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            mem[s] <= '0;
         end
      end else begin
         if (HAS_CLEAR && clr_en) begin
            mem[clr_addr] <= '0;
         end
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_en && w_mask[w]) begin
               mem[w_addr][w*WAY_WIDTH +: WAY_WIDTH] <= w_data[w*WAY_WIDTH +: WAY_WIDTH];
            end
         end
      end
   end

   always_comb begin
      r_data = mem[r_addr];
`ifdef ICACHE_BYPASS_EN
      if (w_en && (w_addr == r_addr)) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_mask[w]) begin
               r_data[w*WAY_WIDTH +: WAY_WIDTH] = w_data[w*WAY_WIDTH +: WAY_WIDTH];
            end
         end
      end
`endif
   end

endmodule

// File: rtl/icache_lookup_stage.sv
// Instruction-cache stage 1: set read of tag/status arrays with metadata alignment,
// flush sweep of the status array. Same-cycle forwarding enabled by ICACHE_BYPASS_EN.
module icache_lookup_stage #(
   parameter int METADATA_WIDTH = 16,
   parameter int NUM_WAYS       = icache_pkg::NUM_WAYS,
   parameter int SET_BITS_WIDTH = icache_pkg::SET_BITS_WIDTH,
   parameter int TAG_WIDTH      = icache_pkg::TAG_WIDTH,
   parameter int STATUS_WIDTH   = icache_pkg::STATUS_WIDTH
) (
   input  logic                             clk,
   input  logic                             arst_n,
   input  logic                             i_halt,
   input  logic [METADATA_WIDTH-1:0]        i_metadata,
   input  logic                             i_metadata_valid,
   input  logic [SET_BITS_WIDTH-1:0]        i_r_set_addr,
   input  logic                             i_r_valid,
   input  logic [SET_BITS_WIDTH-1:0]        i_w_ta_set_addr,
   input  logic [NUM_WAYS*TAG_WIDTH-1:0]    i_w_ta_data,
   input  logic [NUM_WAYS-1:0]              i_w_ta_mask,
   input  logic                             i_w_ta_valid,
   input  logic [SET_BITS_WIDTH-1:0]        i_w_sa_set_addr,
   input  logic [NUM_WAYS*STATUS_WIDTH-1:0] i_w_sa_data,
   input  logic [NUM_WAYS-1:0]              i_w_sa_mask,
   input  logic                             i_w_sa_valid,
   input  logic                             i_miss_state,
   input  logic                             i_flush,
   output logic [NUM_WAYS*TAG_WIDTH-1:0]    o_ta_data,
   output logic                             o_ta_data_valid,
   output logic [NUM_WAYS*STATUS_WIDTH-1:0] o_sa_data,
   output logic                             o_sa_data_valid,
   output logic [METADATA_WIDTH-1:0]        o_metadata,
   output logic                             o_metadata_valid,
   output logic                             o_flush_busy,
   output logic                             o_ready
);

   import icache_pkg::*;

   localparam int NUM_SETS = 2**SET_BITS_WIDTH;
   localparam int TAG_W    = NUM_WAYS*TAG_WIDTH;
   localparam int STAT_W   = NUM_WAYS*STATUS_WIDTH;

   flush_state_e              state_q, state_d;
   logic [SET_BITS_WIDTH-1:0] cnt_q, cnt_d;
   logic                      busy, ready, ta_we, sa_we, clr_en;
   logic [TAG_W-1:0]          ta_rd;
   logic [STAT_W-1:0]         sa_rd;

   // Handshake: o_ready high means a read and both writes presented this cycle are
   // taken at the next rising edge; when low they are dropped, not queued.
   assign busy         = (state_q == FLUSH);
   assign ready        = ~i_halt & ~busy;
   assign o_ready      = ready;
   assign o_flush_busy = busy;
   assign ta_we        = arst_n & ready & i_w_ta_valid & i_miss_state;
   assign sa_we        = arst_n & ready & i_w_sa_valid;
   assign clr_en       = busy & ~i_halt;

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (i_flush && !i_halt) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            if (!i_halt) begin
               if (cnt_q == SET_BITS_WIDTH'(NUM_SETS-1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   icache_way_array #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_WIDTH(TAG_WIDTH),
      .SET_BITS (SET_BITS_WIDTH),
      .HAS_CLEAR(1'b0)
   ) u_tag_array (
      .clk     (clk),
      .rst_n   (arst_n),
      .clr_en  (1'b0),
      .clr_addr(cnt_q),
      .w_en    (ta_we),
      .w_addr  (i_w_ta_set_addr),
      .w_data  (i_w_ta_data),
      .w_mask  (i_w_ta_mask),
      .r_addr  (i_r_set_addr),
      .r_data  (ta_rd)
   );

   icache_way_array #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_WIDTH(STATUS_WIDTH),
      .SET_BITS (SET_BITS_WIDTH),
      .HAS_CLEAR(1'b1)
   ) u_status_array (
      .clk     (clk),
      .rst_n   (arst_n),
      .clr_en  (clr_en),
      .clr_addr(cnt_q),
      .w_en    (sa_we),
      .w_addr  (i_w_sa_set_addr),
      .w_data  (i_w_sa_data),
      .w_mask  (i_w_sa_mask),
      .r_addr  (i_r_set_addr),
      .r_data  (sa_rd)
   );

   // Metadata keeps flowing during a flush; read data registers hold and valids drop.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         o_ta_data        <= '0;
         o_ta_data_valid  <= 1'b0;
         o_sa_data        <= '0;
         o_sa_data_valid  <= 1'b0;
         o_metadata       <= '0;
         o_metadata_valid <= 1'b0;
      end else if (!i_halt) begin
         o_metadata       <= i_metadata;
         o_metadata_valid <= i_metadata_valid;
         if (busy) begin
            o_ta_data_valid <= 1'b0;
            o_sa_data_valid <= 1'b0;
         end else begin
            o_ta_data       <= ta_rd;
            o_ta_data_valid <= i_r_valid;
            o_sa_data       <= sa_rd;
            o_sa_data_valid <= i_r_valid;
         end
      end
   end

endmodule

// File: tb/tb_icache_lookup_stage.sv
// Randomized plus directed bench for icache_lookup_stage against a set-level
// reference model; honours ICACHE_BYPASS_EN the same way the design does.
module tb_icache_lookup_stage;

   logic        clk;
   logic        arst_n;
   logic        i_halt;
   logic [15:0] i_metadata;
   logic        i_metadata_valid;
   logic [3:0]  i_r_set_addr;
   logic        i_r_valid;
   logic [3:0]  i_w_ta_set_addr;
   logic [31:0] i_w_ta_data;
   logic [3:0]  i_w_ta_mask;
   logic        i_w_ta_valid;
   logic [3:0]  i_w_sa_set_addr;
   logic [7:0]  i_w_sa_data;
   logic [3:0]  i_w_sa_mask;
   logic        i_w_sa_valid;
   logic        i_miss_state;
   logic        i_flush;
   logic [31:0] o_ta_data;
   logic        o_ta_data_valid;
   logic [7:0]  o_sa_data;
   logic        o_sa_data_valid;
   logic [15:0] o_metadata;
   logic        o_metadata_valid;
   logic        o_flush_busy;
   logic        o_ready;

   icache_lookup_stage dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .i_halt          (i_halt),
      .i_metadata      (i_metadata),
      .i_metadata_valid(i_metadata_valid),
      .i_r_set_addr    (i_r_set_addr),
      .i_r_valid       (i_r_valid),
      .i_w_ta_set_addr (i_w_ta_set_addr),
      .i_w_ta_data     (i_w_ta_data),
      .i_w_ta_mask     (i_w_ta_mask),
      .i_w_ta_valid    (i_w_ta_valid),
      .i_w_sa_set_addr (i_w_sa_set_addr),
      .i_w_sa_data     (i_w_sa_data),
      .i_w_sa_mask     (i_w_sa_mask),
      .i_w_sa_valid    (i_w_sa_valid),
      .i_miss_state    (i_miss_state),
      .i_flush         (i_flush),
      .o_ta_data       (o_ta_data),
      .o_ta_data_valid (o_ta_data_valid),
      .o_sa_data       (o_sa_data),
      .o_sa_data_valid (o_sa_data_valid),
      .o_metadata      (o_metadata),
      .o_metadata_valid(o_metadata_valid),
      .o_flush_busy    (o_flush_busy),
      .o_ready         (o_ready)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: array contents, flush progress, expected output registers
   logic [31:0] tag_m [16];
   bit          tag_known [16];
   logic [7:0]  stat_m [16];
   bit          m_busy;
   int          m_cnt;
   logic [31:0] e_ta;
   bit          e_ta_known;
   logic [7:0]  e_sa;
   logic        e_tav, e_sav;
   logic [15:0] e_meta;
   logic        e_metav;
   logic        pre_ready;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] mask, input int way_w);
      logic [31:0] r;
      r = old_w;
      for (int w = 0; w < 4; w++)
         for (int b = 0; b < way_w; b++)
            if (mask[w]) r[w*way_w+b] = new_w[w*way_w+b];
      return r;
   endfunction

   task automatic model_step();
      logic [31:0] rd_ta, tmp;
      logic [7:0]  rd_sa;
      bit          rd_known, rdy, ta_commit, sa_commit;
      if (!arst_n) begin
         for (int s = 0; s < 16; s++) stat_m[s] = 8'h00;
         m_busy = 0; m_cnt = 0;
         e_ta = '0; e_ta_known = 1; e_sa = '0; e_tav = 0; e_sav = 0; e_meta = '0; e_metav = 0;
         return;
      end
      rdy       = !i_halt && !m_busy;
      ta_commit = rdy && i_w_ta_valid && i_miss_state;
      sa_commit = rdy && i_w_sa_valid;
      rd_ta     = tag_m[i_r_set_addr];
      rd_known  = tag_known[i_r_set_addr];
      rd_sa     = stat_m[i_r_set_addr];
`ifdef ICACHE_BYPASS_EN
      if (ta_commit && i_w_ta_set_addr == i_r_set_addr)
         rd_ta = merge(rd_ta, i_w_ta_data, i_w_ta_mask, 8);
      if (sa_commit && i_w_sa_set_addr == i_r_set_addr) begin
         tmp   = merge({24'h0, rd_sa}, {24'h0, i_w_sa_data}, i_w_sa_mask, 2);
         rd_sa = tmp[7:0];
      end
`endif
      if (!i_halt) begin
         e_meta  = i_metadata;
         e_metav = i_metadata_valid;
         if (m_busy) begin
            e_tav = 0; e_sav = 0;
         end else begin
            e_ta = rd_ta; e_ta_known = rd_known; e_sa = rd_sa;
            e_tav = i_r_valid; e_sav = i_r_valid;
         end
      end
      if (ta_commit) begin
         tag_m[i_w_ta_set_addr] = merge(tag_m[i_w_ta_set_addr], i_w_ta_data, i_w_ta_mask, 8);
         if (i_w_ta_mask == 4'hF) tag_known[i_w_ta_set_addr] = 1;
      end
      if (sa_commit) begin
         tmp = merge({24'h0, stat_m[i_w_sa_set_addr]}, {24'h0, i_w_sa_data}, i_w_sa_mask, 2);
         stat_m[i_w_sa_set_addr] = tmp[7:0];
      end
      if (m_busy && !i_halt) begin
         stat_m[m_cnt] = 8'h00;
         if (m_cnt == 15) begin m_busy = 0; m_cnt = 0; end
         else m_cnt++;
      end else if (!m_busy && i_flush && !i_halt) begin
         m_busy = 1; m_cnt = 0;
      end
   endtask

   task automatic compare_all();
      check_eq("ready", o_ready, !i_halt && !m_busy);
      check_eq("flush_busy", o_flush_busy, m_busy);
      check_eq("ta_valid", o_ta_data_valid, e_tav);
      check_eq("sa_valid", o_sa_data_valid, e_sav);
      check_eq("sa_data", o_sa_data, e_sa);
      check_eq("metadata", o_metadata, e_meta);
      check_eq("metadata_valid", o_metadata_valid, e_metav);
      if (e_ta_known) check_eq("ta_data", o_ta_data, e_ta);
   endtask

   // driver: one clock with the inputs currently applied
   task automatic cycle();
      @(negedge clk);
      pre_ready = o_ready;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      i_halt = 0; i_flush = 0; i_r_valid = 0; i_metadata_valid = 0;
      i_w_ta_valid = 0; i_w_sa_valid = 0; i_miss_state = 0;
   endtask

   int low_cnt;

   initial begin
      for (int s = 0; s < 16; s++) begin
         tag_m[s] = '0; tag_known[s] = 0; stat_m[s] = '0;
      end
      m_busy = 0; m_cnt = 0;
      i_metadata = '0; i_r_set_addr = '0; i_w_ta_set_addr = '0; i_w_ta_data = '0;
      i_w_ta_mask = '0; i_w_sa_set_addr = '0; i_w_sa_data = '0; i_w_sa_mask = '0;
      idle_inputs();

      // reset
      arst_n = 0;
      cycle(); cycle();
      check_eq("reset_ta", o_ta_data, 32'h0);
      arst_n = 1;

      // read set 3 straight after reset
      i_r_valid = 1; i_r_set_addr = 4'd3;
      cycle();
      check_eq("rst_read_sa", o_sa_data, 8'h00);
      check_eq("rst_read_valid", o_sa_data_valid, 1'b1);
      idle_inputs();

      // give every tag set a known value
      for (int s = 0; s < 16; s++) begin
         i_w_ta_valid = 1; i_miss_state = 1; i_w_ta_mask = 4'hF;
         i_w_ta_set_addr = s[3:0]; i_w_ta_data = $urandom;
         cycle();
      end
      idle_inputs();

      // masked status write then read back
      i_w_sa_valid = 1; i_w_sa_set_addr = 4'd5; i_w_sa_data = 8'hE4; i_w_sa_mask = 4'b0101;
      cycle();
      idle_inputs();
      i_r_valid = 1; i_r_set_addr = 4'd5;
      cycle();
      idle_inputs();

      // tag write gated by miss_state
      i_w_ta_valid = 1; i_w_ta_set_addr = 4'd2; i_w_ta_data = 32'hAABBCCDD; i_w_ta_mask = 4'hF;
      i_miss_state = 0;
      cycle();
      idle_inputs();
      i_r_valid = 1; i_r_set_addr = 4'd2;
      cycle();
      i_r_valid = 0;
      i_w_ta_valid = 1; i_miss_state = 1;
      cycle();
      idle_inputs();
      i_r_valid = 1; i_r_set_addr = 4'd2;
      cycle();
      check_eq("miss_gate_ta", o_ta_data, 32'hAABBCCDD);
      idle_inputs();

      // same-cycle write/read collision on set 7
      i_w_sa_valid = 1; i_w_sa_set_addr = 4'd7; i_w_sa_data = 8'hFF; i_w_sa_mask = 4'hF;
      i_r_valid = 1; i_r_set_addr = 4'd7;
      cycle();
`ifdef ICACHE_BYPASS_EN
      check_eq("collision_sa", o_sa_data, 8'hFF);
`else
      check_eq("collision_sa", o_sa_data, 8'h00);
`endif
      idle_inputs();

      // fill, flush with a 3-cycle halt mid-sweep, then read everything back
      for (int s = 0; s < 16; s++) begin
         i_w_sa_valid = 1; i_w_sa_set_addr = s[3:0]; i_w_sa_data = 8'hFF; i_w_sa_mask = 4'hF;
         cycle();
      end
      idle_inputs();
      i_flush = 1;
      cycle();
      i_flush = 0;
      low_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         i_halt = (i >= 4 && i <= 6);
         i_r_valid = 1; i_r_set_addr = $urandom_range(0, 15);
         cycle();
         if (!pre_ready) low_cnt++;
      end
      check_eq("flush_ready_low_cycles", low_cnt, 19);
      idle_inputs();
      for (int s = 0; s < 16; s++) begin
         i_r_valid = 1; i_r_set_addr = s[3:0];
         cycle();
         check_eq("post_flush_sa", o_sa_data, 8'h00);
      end
      idle_inputs();

      // halt with reads, metadata and writes presented
      i_r_valid = 1; i_r_set_addr = 4'd9;
      cycle();
      i_halt = 1; i_r_set_addr = 4'd2; i_metadata = 16'h1234; i_metadata_valid = 1;
      i_w_sa_valid = 1; i_w_sa_set_addr = 4'd2; i_w_sa_data = 8'hFF; i_w_sa_mask = 4'hF;
      i_w_ta_valid = 1; i_miss_state = 1; i_w_ta_set_addr = 4'd2; i_w_ta_data = 32'h11223344;
      i_w_ta_mask = 4'hF;
      for (int i = 0; i < 4; i++) cycle();
      idle_inputs();
      i_r_valid = 1; i_r_set_addr = 4'd2;
      cycle();
      check_eq("halt_no_tag_write", o_ta_data, 32'hAABBCCDD);
      check_eq("halt_no_sa_write", o_sa_data, 8'h00);
      idle_inputs();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         arst_n           = ($urandom_range(0, 99) != 0);
         i_halt           = ($urandom_range(0, 4) == 0);
         i_flush          = ($urandom_range(0, 24) == 0);
         i_metadata       = $urandom;
         i_metadata_valid = $urandom_range(0, 1);
         i_r_valid        = $urandom_range(0, 1);
         i_r_set_addr     = $urandom_range(0, 15);
         i_w_ta_valid     = $urandom_range(0, 1);
         i_miss_state     = $urandom_range(0, 1);
         i_w_ta_set_addr  = ($urandom_range(0, 1) == 0) ? i_r_set_addr : 4'($urandom_range(0, 15));
         i_w_ta_data      = $urandom;
         i_w_ta_mask      = $urandom_range(0, 15);
         i_w_sa_valid     = $urandom_range(0, 1);
         i_w_sa_set_addr  = ($urandom_range(0, 1) == 0) ? i_r_set_addr : 4'($urandom_range(0, 15));
         i_w_sa_data      = $urandom;
         i_w_sa_mask      = $urandom_range(0, 15);
         cycle();
      end
      arst_n = 1;
      idle_inputs();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
